// File: rtl/uart_tx_framer.sv
// UART transmit framer: 1 start, 8 data (LSB first), even parity, 1 stop bit.
// Includes its own x16 baud-tick generator selected by baud_select.
module uart_tx_framer #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic       Tx_WR,
  input  logic       Tx_EN,
  input  logic [2:0] baud_select,
  output logic       TxD,
  output logic       Tx_BUSY
);

  localparam int unsigned DIV_W = 16;

  function automatic int unsigned div_of(input int unsigned baud);
    return (CLK_FREQ + 8 * baud) / (16 * baud);
  endfunction

  localparam logic [DIV_W-1:0] DIV_300    = DIV_W'(div_of(300));
  localparam logic [DIV_W-1:0] DIV_1200   = DIV_W'(div_of(1200));
  localparam logic [DIV_W-1:0] DIV_4800   = DIV_W'(div_of(4800));
  localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(div_of(9600));
  localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(div_of(19200));
  localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(div_of(38400));
  localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(div_of(57600));
  localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(div_of(115200));

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_tick_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shreg;
  logic             r_parity;
  logic [2:0]       r_baud;
  logic             r_txd;
  logic             r_busy;

  logic [DIV_W-1:0] w_div;
  logic             w_accept;
  logic             w_tick;
  logic             w_bit_end;

  // Divisor follows the baud code latched at accept, not the live input.
  always_comb begin
    w_div = DIV_300;
    case (r_baud)
      3'd0:    w_div = DIV_300;
      3'd1:    w_div = DIV_1200;
      3'd2:    w_div = DIV_4800;
      3'd3:    w_div = DIV_9600;
      3'd4:    w_div = DIV_19200;
      3'd5:    w_div = DIV_38400;
      3'd6:    w_div = DIV_57600;
      3'd7:    w_div = DIV_115200;
      default: w_div = DIV_300;
    endcase
  end

  assign w_accept  = Tx_WR & Tx_EN & ~r_busy;
  assign w_tick    = (r_state != S_IDLE) && (r_div_cnt == (w_div - DIV_W'(1)));
  assign w_bit_end = w_tick && (r_tick_cnt == 4'd15);

  // Baud divisor and x16 tick counters; restarted on accept so bit 0 is a full period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (w_accept) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      if (w_tick) begin
        r_div_cnt  <= '0;
        r_tick_cnt <= r_tick_cnt + 4'd1;
      end else begin
        r_div_cnt  <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Frame sequencer; TxD and Tx_BUSY are driven straight from registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_parity  <= 1'b0;
      r_baud    <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_accept) begin
            r_shreg   <= Tx_DATA;
            r_parity  <= ^Tx_DATA;
            r_baud    <= baud_select;
            r_bit_cnt <= '0;
            r_txd     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_txd   <= r_shreg[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == 3'd7) begin
              r_txd   <= r_parity;
              r_state <= S_PARITY;
            end else begin
              r_shreg   <= r_shreg >> 1;
              r_txd     <= r_shreg[1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_txd   <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign TxD     = r_txd;
  assign Tx_BUSY = r_busy;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: stimulus queues expected frames,
// a monitor walks each frame on TxD/Tx_BUSY and compares bit by bit.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] Tx_DATA = 8'h00;
  logic       Tx_WR = 1'b0;
  logic       Tx_EN = 1'b0;
  logic [2:0] baud_select = 3'd0;
  logic       TxD;
  logic       Tx_BUSY;

  typedef struct {
    logic [7:0]  data;
    logic        par;
    int unsigned period;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_active = 1'b0;

  uart_tx_framer #(.CLK_FREQ(50_000_000)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .Tx_DATA    (Tx_DATA),
    .Tx_WR      (Tx_WR),
    .Tx_EN      (Tx_EN),
    .baud_select(baud_select),
    .TxD        (TxD),
    .Tx_BUSY    (Tx_BUSY)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: cycle 0 is the first negedge with Tx_BUSY high.
  initial begin
    exp_t        e;
    logic [10:0] bits;
    int unsigned p;
    forever begin
      @(negedge clk);
      if (rst_n && Tx_BUSY) begin
        mon_active = 1'b1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame: busy rose with no frame queued (t=%0t)", $time);
          for (int k = 0; k < 200000 && Tx_BUSY && rst_n; k++) @(negedge clk);
        end else begin
          e    = exp_q.pop_front();
          p    = e.period;
          bits = {1'b1, e.par, e.data, 1'b0};
          for (int unsigned c = 0; c <= 11 * p; c++) begin
            if (c != 0) @(negedge clk);
            if (!rst_n) begin
              check($sformatf("f%02h_abort_txd", e.data), 32'(TxD), 32'd1);
              check($sformatf("f%02h_abort_busy", e.data), 32'(Tx_BUSY), 32'd0);
              break;
            end
            if (c == 11 * p) begin
              check($sformatf("f%02h_end_busy", e.data), 32'(Tx_BUSY), 32'd0);
              check($sformatf("f%02h_end_txd", e.data), 32'(TxD), 32'd1);
            end else begin
              if ((c % p == 0) || (c % p == p - 1))
                check($sformatf("f%02h_bit%0d_c%0d", e.data, c / p, c % p), 32'(TxD), 32'(bits[c / p]));
              if (c == 11 * p - 1)
                check($sformatf("f%02h_busy_last", e.data), 32'(Tx_BUSY), 32'd1);
            end
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic write_byte(input logic [7:0] d, input logic [2:0] b, input logic par,
                            input int unsigned p);
    exp_t e;
    @(negedge clk);
    Tx_DATA     = d;
    baud_select = b;
    Tx_WR       = 1'b1;
    e.data = d; e.par = par; e.period = p;
    exp_q.push_back(e);
    @(negedge clk);
    Tx_WR = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned k = 0;
    bit pending;
    do begin
      @(negedge clk);
      #1;
      k++;
      pending = Tx_BUSY || mon_active || (exp_q.size() != 0);
    end while (pending && k < budget);
    check({name, "_done"}, 32'(pending), 32'd0);
  endtask

  initial begin
    int unsigned k;
    // 1: reset held with arbitrary inputs, then released
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      Tx_DATA = 8'($urandom); Tx_WR = 1'($urandom); Tx_EN = 1'($urandom);
      baud_select = 3'($urandom);
      check("rst_txd", 32'(TxD), 32'd1);
      check("rst_busy", 32'(Tx_BUSY), 32'd0);
    end
    @(negedge clk);
    Tx_WR = 1'b0; Tx_EN = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rel_txd", 32'(TxD), 32'd1);
      check("rel_busy", 32'(Tx_BUSY), 32'd0);
    end

    // 2: 115200 baud, 0x55, parity 0, bit = 432 cycles
    write_byte(8'h55, 3'd7, 1'b0, 432);
    wait_done("t2", 11 * 432 + 50);

    // 3: 9600 baud, 0x01, parity 1, bit = 5216 cycles
    write_byte(8'h01, 3'd3, 1'b1, 5216);
    wait_done("t3", 11 * 5216 + 50);

    // 4: 0xA3 with an ignored mid-frame write, then back-to-back 0xC1
    write_byte(8'hA3, 3'd7, 1'b0, 432);
    repeat (1000) @(negedge clk);
    Tx_DATA = 8'hFF; baud_select = 3'd0; Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0; Tx_DATA = 8'h00;
    k = 0;
    do begin @(negedge clk); k++; end while (Tx_BUSY && k < 5000);
    check("t4_idle_seen", 32'(Tx_BUSY), 32'd0);
    begin
      exp_t e;
      Tx_DATA = 8'hC1; baud_select = 3'd7; Tx_WR = 1'b1;
      e.data = 8'hC1; e.par = 1'b1; e.period = 432;
      exp_q.push_back(e);
    end
    @(negedge clk);
    Tx_WR = 1'b0;
    check("b2b_busy", 32'(Tx_BUSY), 32'd1);
    check("b2b_txd", 32'(TxD), 32'd0);

    // 5: drop Tx_EN during DATA of 0xC1; frame completes; later write refused
    repeat (1500) @(negedge clk);
    Tx_EN = 1'b0;
    wait_done("t5", 11 * 432 + 50);
    @(negedge clk);
    Tx_DATA = 8'h77; Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("en0_busy", 32'(Tx_BUSY), 32'd0);
      check("en0_txd", 32'(TxD), 32'd1);
    end
    Tx_EN = 1'b1;

    // 6: reset during data bit 4 of 0x96, then a clean 0x80 frame
    write_byte(8'h96, 3'd7, 1'b0, 432);
    repeat (5 * 432 + 200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_txd", 32'(TxD), 32'd1);
    check("t6_rst_busy", 32'(Tx_BUSY), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_done("t6_abort", 20);
    write_byte(8'h80, 3'd7, 1'b1, 432);
    wait_done("t6", 11 * 432 + 50);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
